// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// The baud divisor and the word are captured together when a word is accepted.
module uart_tx_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int DIV_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_serial_out
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Mode 3 is not a legal parity mode and behaves like "none".
  localparam bit HAS_PARITY = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [DIV_W-1:0]     div_reg;
  logic [DIV_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 par_bit;
  logic                 bit_end;

  assign bit_end = (baud_cnt == div_reg - DIV_ONE);

  // bit_idx counts data bits in DATA and stop bits in STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      shreg         <= '0;
      div_reg       <= '0;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      par_bit       <= 1'b0;
      tx_serial_out <= 1'b1;
      tx_ready      <= 1'b1;
      tx_busy       <= 1'b0;
      tx_done       <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + DIV_ONE;
      case (state)
        IDLE: begin
          tx_serial_out <= 1'b1;
          if (tx_valid && tx_ready) begin
            shreg         <= tx_data;
            div_reg       <= (baud_div == '0) ? DIV_ONE : baud_div;
            par_bit       <= (PARITY_MODE == 2) ? ~^tx_data : ^tx_data;
            baud_cnt      <= '0;
            state         <= START;
            tx_ready      <= 1'b0;
            tx_busy       <= 1'b1;
            tx_serial_out <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state         <= DATA;
            bit_idx       <= '0;
            tx_serial_out <= shreg[0];
            shreg         <= shreg >> 1;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (HAS_PARITY) begin
                state         <= PARITY;
                tx_serial_out <= par_bit;
              end else begin
                state         <= STOP;
                tx_serial_out <= 1'b1;
              end
            end else begin
              bit_idx       <= bit_idx + IDX_ONE;
              tx_serial_out <= shreg[0];
              shreg         <= shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state         <= STOP;
            bit_idx       <= '0;
            tx_serial_out <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_idx == LAST_STOP) begin
              state    <= IDLE;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + IDX_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: three builds (8N1, 8E2, 7O1) share stimulus,
// and a selector routes the active build's outputs to the checks.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [7:0]  tx_data;
  logic        tx_valid;
  int          sel;
  int          compared = 0;
  int          mismatched = 0;

  logic valid_a, valid_b, valid_c;
  logic ready_a, ready_b, ready_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic line_a, line_b, line_c;
  logic ready_m, busy_m, done_m, line_m;

  always #5 clk = ~clk;

  assign valid_a = tx_valid && (sel == 0);
  assign valid_b = tx_valid && (sel == 1);
  assign valid_c = tx_valid && (sel == 2);

  always_comb begin
    ready_m = ready_a;
    busy_m  = busy_a;
    done_m  = done_a;
    line_m  = line_a;
    if (sel == 1) begin
      ready_m = ready_b; busy_m = busy_b; done_m = done_b; line_m = line_b;
    end else if (sel == 2) begin
      ready_m = ready_c; busy_m = busy_c; done_m = done_c; line_m = line_c;
    end
  end

  uart_tx_cfg #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .DIV_W(16)) dut_8n1 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .tx_data(tx_data), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx_busy(busy_a), .tx_done(done_a), .tx_serial_out(line_a));

  uart_tx_cfg #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2), .DIV_W(16)) dut_8e2 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .tx_data(tx_data), .tx_valid(valid_b),
    .tx_ready(ready_b), .tx_busy(busy_b), .tx_done(done_b), .tx_serial_out(line_b));

  uart_tx_cfg #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1), .DIV_W(16)) dut_7o1 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .tx_data(tx_data[6:0]), .tx_valid(valid_c),
    .tx_ready(ready_c), .tx_busy(busy_c), .tx_done(done_c), .tx_serial_out(line_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $display("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
      $error("[TB] %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Raises tx_valid for the accept edge; leaves it high when hold is set.
  task automatic applyStimulus(input int which, input logic [7:0] data, input logic [15:0] div,
                               input bit hold);
    sel      = which;
    tx_data  = data;
    baud_div = div;
    tx_valid = 1'b1;
    tick();
    if (!hold) tx_valid = 1'b0;
  endtask

  // seq[i] is the i-th expected line bit; each bit must last exactly div clocks.
  task automatic checkFrame(input string tag, input logic [15:0] seq, input int nbits,
                            input int div);
    for (int i = 0; i < nbits * div; i++) begin
      checkOutput({tag, "_line"}, line_m, seq[i / div]);
      checkOutput({tag, "_done_low"}, done_m, 1'b0);
      checkOutput({tag, "_busy"}, busy_m, 1'b1);
      checkOutput({tag, "_ready_low"}, ready_m, 1'b0);
      tick();
    end
    checkOutput({tag, "_done_pulse"}, done_m, 1'b1);
    checkOutput({tag, "_ready_back"}, ready_m, 1'b1);
    checkOutput({tag, "_busy_clear"}, busy_m, 1'b0);
    checkOutput({tag, "_line_idle"}, line_m, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    sel      = 0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    baud_div = 16'd4;
    #23;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkOutput("reset_line", line_m, 1'b1);
      checkOutput("reset_ready", ready_m, 1'b1);
      checkOutput("reset_busy", busy_m, 1'b0);
      checkOutput("reset_done", done_m, 1'b0);
    end
    rst = 1'b0;
    tick();
    tick();

    $display("[TB] 8N1 div=4 word 0xA5, divisor changed mid-frame");
    applyStimulus(0, 8'hA5, 16'd4, 1'b0);
    baud_div = 16'd7;
    checkFrame("t1_a5", 16'h034A, 10, 4);
    tick();
    checkOutput("t1_done_one_cycle", done_m, 1'b0);

    $display("[TB] 8E2 div=3 word 0x07");
    applyStimulus(1, 8'h07, 16'd3, 1'b0);
    checkFrame("t2_07", 16'h0E0E, 12, 3);
    tick();
    checkOutput("t2_done_one_cycle", done_m, 1'b0);

    $display("[TB] 7O1 div=2 word 0x55");
    applyStimulus(2, 8'h55, 16'd2, 1'b0);
    checkFrame("t3_55", 16'h03AA, 10, 2);
    tick();

    $display("[TB] back-to-back with tx_valid held high");
    applyStimulus(0, 8'h11, 16'd2, 1'b1);
    tx_data = 8'h22;
    checkFrame("t4_11", 16'h0222, 10, 2);
    tick();
    tx_valid = 1'b0;
    checkFrame("t4_22", 16'h0244, 10, 2);
    tick();
    checkOutput("t4_done_one_cycle", done_m, 1'b0);
    checkOutput("t4_no_third_frame", ready_m, 1'b1);

    $display("[TB] reset during data bits of 0xFF");
    applyStimulus(0, 8'hFF, 16'd4, 1'b0);
    for (int i = 0; i < 13; i++) tick();
    checkOutput("t5_mid_data_busy", busy_m, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_line", line_m, 1'b1);
    checkOutput("t5_rst_ready", ready_m, 1'b1);
    checkOutput("t5_rst_busy", busy_m, 1'b0);
    checkOutput("t5_rst_done", done_m, 1'b0);
    #10;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      checkOutput("t5_no_done_after_abort", done_m, 1'b0);
      checkOutput("t5_idle_line", line_m, 1'b1);
    end
    applyStimulus(0, 8'hA5, 16'd4, 1'b0);
    checkFrame("t5_fresh_a5", 16'h034A, 10, 4);
    tick();

    $display("[TB] baud_div=0 treated as 1, word 0x3C");
    applyStimulus(0, 8'h3C, 16'd0, 1'b0);
    checkFrame("t6_3c", 16'h0278, 10, 1);
    tick();
    checkOutput("t6_done_one_cycle", done_m, 1'b0);
    applyStimulus(0, 8'h11, 16'd1, 1'b0);
    checkFrame("t6_after_zero", 16'h0222, 10, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
